// File: rtl/comp_share_arbiter.sv
// comp_share_arbiter: round-robin front end for a single shared 4-bit magnitude
// comparator. One transaction at a time walks IDLE -> DRIVE -> CAPT -> RESP.
// The winner's operands are registered onto cmp_a/cmp_b. The comparator's
// {GT,EQ,LT} result comes back on cmp_r and is returned on a valid/ready channel.
module comp_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       cmp_a,
    output logic [WIDTH-1:0]       cmp_b,
    input  logic [2:0]             cmp_r,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2:0]             rsp_r,
    output logic                   rsp_err,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPT, RESP} state_t;

    state_t state, state_next;

    logic [N_REQ-1:0][WIDTH-1:0] a_vec, b_vec;
    logic [ID_W-1:0]             ptr, ptr_next;
    logic [ID_W-1:0]             win, cand;
    logic                        found;
    logic                        take, capture, done;
    logic                        r_onehot;

    assign a_vec = a_in;
    assign b_vec = b_in;
    assign busy  = (state != IDLE);

    assign r_onehot = (cmp_r == 3'b100) || (cmp_r == 3'b010) || (cmp_r == 3'b001);

    // Round-robin pick: first asserted request at or after ptr, wrapping.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % N_REQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // The pointer moves to one past the winner so that the winner has the lowest priority next time.
    assign ptr_next = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    take       = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: state_next = CAPT;
            CAPT: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                // rsp_valid is always high in RESP, so rsp_ready alone completes the handshake.
                if (rsp_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: grant pulse, operand registers, pointer and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            gnt <= take ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
            if (take) begin
                cmp_a  <= a_vec[win];
                cmp_b  <= b_vec[win];
                rsp_id <= win;
                ptr    <= ptr_next;
            end
            if (capture) begin
                rsp_r     <= cmp_r;
                rsp_err   <= ~r_onehot;
                rsp_valid <= 1'b1;
            end else if (done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Directed bench for comp_share_arbiter with a behavioural comparator.
// The comparator result can be overridden to inject an illegal value.
module tb_comp_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] a_in, b_in;
    logic [3:0]  gnt;
    logic [3:0]  cmp_a, cmp_b;
    logic [2:0]  cmp_r;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [2:0]  rsp_r;
    logic        rsp_err, busy;
    logic        force_en;
    logic [2:0]  force_val;

    int n_checks = 0;
    int n_fail   = 0;

    comp_share_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_r(cmp_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy)
    );

    assign cmp_r = force_en ? force_val : {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0; force_en = 1'b0; rsp_ready = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
    endtask

    // Runs one transaction for a single requester and reports what was observed.
    task automatic do_txn(input int id, input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] g, output logic [1:0] rid,
                          output logic [2:0] r, output logic e, output int lat,
                          output bit to);
        bit seen;
        to = 1'b0; g = '0; rid = '0; r = '0; e = 1'b0; lat = 0; seen = 1'b0;
        req = 4'b0001 << id;
        a_in[id*4 +: 4] = a;
        b_in[id*4 +: 4] = b;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (gnt !== 4'b0000) begin g = gnt; break; end
        end
        req = '0;
        if (g === 4'b0000) begin to = 1'b1; return; end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid === 1'b1) begin
                rid = rsp_id; r = rsp_r; e = rsp_err; seen = 1'b1;
                break;
            end
        end
        if (!seen) begin to = 1'b1; return; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b0;
        force_en = 1'b0; force_val = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({gnt, cmp_a, cmp_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_gnt_cmp: got gnt=%b a=%h b=%h, want all 0", gnt, cmp_a, cmp_b);
        end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_err, busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rsp: got v=%b id=%0d r=%b err=%b busy=%b, want all 0",
                     rsp_valid, rsp_id, rsp_r, rsp_err, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] g; logic [1:0] rid; logic [2:0] r; logic e; int lat; bit to;
        req = 4'b0010; a_in[7:4] = 4'd4; b_in[7:4] = 4'd3; rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (gnt !== 4'b0010 || cmp_a !== 4'd4 || cmp_b !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b a=%0d b=%0d busy=%b, want 0010 4 3 1",
                     gnt, cmp_a, cmp_b, busy);
        end
        req = '0;
        @(posedge clk); #1;
        n_checks++;
        if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || cmp_a !== 4'd4) begin
            n_fail++;
            $display("FAIL single_drive: got gnt=%b v=%b a=%0d, want 0000 0 4", gnt, rsp_valid, cmp_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_r !== 3'b100 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d r=%b err=%b, want 1 1 100 0",
                     rsp_valid, rsp_id, rsp_r, rsp_err);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_handshake: got v=%b busy=%b, want 0 0", rsp_valid, busy);
        end
        do_txn(1, 4'd0, 4'd0, g, rid, r, e, lat, to); // second pass, equal-to-zero case
        n_checks++;
        if (to || r !== 3'b010 || rid !== 2'd1) begin
            n_fail++;
            $display("FAIL single_zero: got to=%0d r=%b id=%0d, want 0 010 1", to, r, rid);
        end
    endtask

    task automatic test_eq_lt();
        logic [3:0] g; logic [1:0] rid; logic [2:0] r; logic e; int lat; bit to;
        do_txn(0, 4'd15, 4'd15, g, rid, r, e, lat, to);
        n_checks++;
        if (to || g !== 4'b0001 || rid !== 2'd0 || r !== 3'b010 || e !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL eq: got to=%0d gnt=%b id=%0d r=%b err=%b lat=%0d, want 0 0001 0 010 0 2",
                     to, g, rid, r, e, lat);
        end
        do_txn(2, 4'd3, 4'd4, g, rid, r, e, lat, to);
        n_checks++;
        if (to || g !== 4'b0100 || rid !== 2'd2 || r !== 3'b001 || e !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL lt: got to=%0d gnt=%b id=%0d r=%b err=%b lat=%0d, want 0 0100 2 001 0 2",
                     to, g, rid, r, e, lat);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [5];
        logic [3:0] gv [5];
        int gcyc [5];
        int ng;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        ng = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            a_in[i*4 +: 4] = 4'(i + 5);
            b_in[i*4 +: 4] = 4'd6;
        end
        rsp_ready = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(posedge clk); #1;
            if (gnt !== 4'b0000) begin
                gv[ng] = gnt; gcyc[ng] = c; ng++;
            end
        end
        req = '0;
        n_checks++;
        if (ng != 5) begin
            n_fail++;
            $display("FAIL fair_count: got %0d grants, want 5", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (gv[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got gnt=%b, want %b", i, gv[i], exp_g[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (gcyc[i] - gcyc[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL fair_gap[%0d]: got %0d cycles, want 4", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit seen;
        int stall_bad;
        seen = 1'b0; stall_bad = 0;
        apply_reset();
        rsp_ready = 1'b0;
        a_in[3:0] = 4'd9; b_in[3:0] = 4'd2;
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_first_rsp: got no rsp_valid within 20 cycles, want rsp_valid=1");
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_r !== 3'b100 || gnt !== 4'b0000 || rsp_id !== 2'd0) begin
                n_fail++;
                stall_bad++;
                $display("FAIL bp_stall[%0d]: got v=%b r=%b gnt=%b id=%0d, want 1 100 0000 0",
                         i, rsp_valid, rsp_r, gnt, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_handshake: got v=%b gnt=%b, want 0 0000", rsp_valid, gnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_next_gnt: got gnt=%b, want 0001", gnt);
        end
        drain();
    endtask

    task automatic test_bad_result();
        logic [3:0] g; logic [1:0] rid; logic [2:0] r; logic e; int lat; bit to;
        force_val = 3'b110; force_en = 1'b1;
        do_txn(3, 4'd1, 4'd2, g, rid, r, e, lat, to);
        force_en = 1'b0;
        n_checks++;
        if (to || rid !== 2'd3 || r !== 3'b110 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_result: got to=%0d id=%0d r=%b err=%b, want 0 3 110 1", to, rid, r, e);
        end
        do_txn(3, 4'd2, 4'd1, g, rid, r, e, lat, to);
        n_checks++;
        if (to || r !== 3'b100 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_clear: got to=%0d r=%b err=%b, want 0 100 0", to, r, e);
        end
    endtask

    task automatic test_reset_capt();
        bit gseen;
        int spurious;
        gseen = 1'b0; spurious = 0;
        apply_reset();
        a_in[11:8] = 4'd7; b_in[11:8] = 4'd1;
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (gnt !== 4'b0000) begin gseen = 1'b1; break; end
        end
        req = '0;
        @(posedge clk); #1; // now in CAPT
        n_checks++;
        if (!gseen || busy !== 1'b1 || rsp_valid !== 1'b0 || cmp_a !== 4'd7) begin
            n_fail++;
            $display("FAIL rc_setup: got gseen=%0d busy=%b v=%b a=%0d, want 1 1 0 7",
                     gseen, busy, rsp_valid, cmp_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_r, rsp_err, busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL rc_clear: got gnt=%b a=%0d b=%0d v=%b id=%0d r=%b err=%b busy=%b, want all 0",
                     gnt, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_r, rsp_err, busy);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || gnt !== 4'b0000) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL rc_no_rsp: got %0d cycles with rsp_valid/gnt, want 0", spurious);
        end
        req = 4'b1101;
        @(posedge clk); #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rc_ptr: got gnt=%b, want 0001", gnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_eq_lt();
        test_fairness();
        test_backpressure();
        test_bad_result();
        test_reset_capt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
